// File: rtl/pio_pkg.sv
// Purpose: shared register offsets and mode encodings for the bidirectional PIO.
// Latency: n/a (constants only).
// Backpressure: n/a; the bus slave has zero wait states.
package pio_pkg;

    // Register word offsets on the 3-bit address bus
    localparam logic [2:0] PIO_DATA    = 3'd0;
    localparam logic [2:0] PIO_DIR     = 3'd1;
    localparam logic [2:0] PIO_IRQMASK = 3'd2;
    localparam logic [2:0] PIO_EDGECAP = 3'd3;
    localparam logic [2:0] PIO_OUTSET  = 3'd4;
    localparam logic [2:0] PIO_OUTCLR  = 3'd5;

    // Capture edge selection
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Interrupt source selection
    localparam int IRQ_LEVEL = 0;
    localparam int IRQ_EDGE  = 1;

endpackage

// File: rtl/pio_bidir_irq_if.sv
// Purpose: Avalon-MM slave bus bundle (address, chipselect, write_n, writedata, readdata).
// Latency: n/a; readdata is combinational in the slave.
// Backpressure: none; no waitrequest, every access completes in one cycle.
interface pio_bidir_irq_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/pio_sync_edge.sv
// Purpose: two-flop input synchroniser plus previous-sample register and edge detector.
// Latency: in_port sampled at edge k -> in_sync and edge_pulse valid after edge k+1.
// Backpressure: none; free-running every cycle.
// Ports: clk, reset_n (sync, active-low), in_port (async pins),
//        in_sync (synchronised level), edge_pulse (one-cycle pulse per selected edge).
module pio_sync_edge
    import pio_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int EDGE_TYPE = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] in_sync,
    output logic [WIDTH-1:0] edge_pulse
);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] prev;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1   <= '0;
            s2   <= '0;
            prev <= '0;
        end else begin
            s1   <= in_port;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign in_sync = s2;

    // prev resets to 0, so a pin held high through reset yields one rising capture.
    always_comb begin
        edge_pulse = '0;
        case (EDGE_TYPE)
            EDGE_FALL: edge_pulse = ~s2 & prev;
            EDGE_ANY:  edge_pulse = s2 ^ prev;
            default:   edge_pulse = s2 & ~prev;
        endcase
    end

endmodule

// File: rtl/pio_bidir_irq.sv
// Purpose: WIDTH-bit bidirectional PIO with set/clear, edge capture (W1C) and maskable irq.
// Latency: pin change at edge k -> DATA read after k+1, EDGECAP set at k+2, irq at k+3.
// Backpressure: none; zero-wait-state slave, writes take effect on the next clk edge.
// Ports: clk, reset_n (sync, active-low), bus (Avalon-MM slave modport),
//        in_port (async pins), out_port (output data), out_en (1 = drive pin), irq (registered).
module pio_bidir_irq
    import pio_pkg::*;
#(
    parameter int          WIDTH     = 8,
    parameter logic [31:0] RESET_OUT = 32'h0,
    parameter logic [31:0] RESET_DIR = 32'h0,
    parameter int          EDGE_TYPE = EDGE_RISE,
    parameter int          IRQ_MODE  = IRQ_EDGE
) (
    input  logic             clk,
    input  logic             reset_n,
    pio_bidir_irq_if.slave   bus,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] out_en,
    output logic             irq
);

    logic             wr;
    logic [WIDTH-1:0] wdat;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] in_sync;
    logic [WIDTH-1:0] edge_pulse;
    logic [WIDTH-1:0] ec_clr;
    logic [WIDTH-1:0] irq_src;
    logic [WIDTH-1:0] rd_bits;
    logic [31:0]      rd_word;

    // Bits above WIDTH are intentionally ignored on writes.
    logic [31:0]      unused_wdata;
    assign unused_wdata = bus.writedata;

    assign wr   = bus.chipselect & ~bus.write_n;
    assign wdat = bus.writedata[WIDTH-1:0];

    pio_sync_edge #(
        .WIDTH     (WIDTH),
        .EDGE_TYPE (EDGE_TYPE)
    ) u_sync_edge (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_port    (in_port),
        .in_sync    (in_sync),
        .edge_pulse (edge_pulse)
    );

    // Control registers. OUTSET/OUTCLR act on the current out_port value,
    // so software never needs a read-modify-write.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_port <= RESET_OUT[WIDTH-1:0];
            out_en   <= RESET_DIR[WIDTH-1:0];
            irqmask  <= '0;
        end else if (wr) begin
            case (bus.address)
                PIO_DATA:    out_port <= wdat;
                PIO_DIR:     out_en   <= wdat;
                PIO_IRQMASK: irqmask  <= wdat;
                PIO_OUTSET:  out_port <= out_port | wdat;
                PIO_OUTCLR:  out_port <= out_port & ~wdat;
                default:     ;
            endcase
        end
    end

    assign ec_clr = (wr && bus.address == PIO_EDGECAP) ? wdat : '0;

    // A new edge is OR-ed in after the clear so a coincident set wins.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            edgecapture <= '0;
        end else begin
            edgecapture <= (edgecapture & ~ec_clr) | edge_pulse;
        end
    end

    assign irq_src = (IRQ_MODE == IRQ_LEVEL) ? in_sync : edgecapture;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irq <= 1'b0;
        end else begin
            irq <= |(irq_src & irqmask);
        end
    end

    always_comb begin
        rd_bits = '0;
        case (bus.address)
            PIO_DATA:    rd_bits = (out_en & out_port) | (~out_en & in_sync);
            PIO_DIR:     rd_bits = out_en;
            PIO_IRQMASK: rd_bits = irqmask;
            PIO_EDGECAP: rd_bits = edgecapture;
            default:     rd_bits = '0;
        endcase
    end

    always_comb begin
        rd_word              = '0;
        rd_word[WIDTH-1:0]   = rd_bits;
    end

    assign bus.readdata = rd_word;

endmodule

// File: tb/tb_pio_bidir_irq.sv
// Purpose: self-checking bench for pio_bidir_irq using a scoreboard queue of expectations.
// Latency: expectations are pushed as stimulus is applied and drained at the checking negedge.
// Backpressure: n/a.
module tb_pio_bidir_irq;
    import pio_pkg::*;

    localparam int W = 8;

    localparam int K_REG  = 0;
    localparam int K_OUT  = 1;
    localparam int K_DIR  = 2;
    localparam int K_IRQ  = 3;

    typedef struct {
        string       tag;
        int          kind;
        logic [2:0]  addr;
        logic [31:0] val;
    } exp_t;

    logic         clk;
    logic         reset_n;
    logic [W-1:0] in_port;
    logic [W-1:0] out_port;
    logic [W-1:0] out_en;
    logic         irq;

    int tests  = 0;
    int failed = 0;
    exp_t sb[$];

    pio_bidir_irq_if bus ();

    pio_bidir_irq #(
        .WIDTH     (W),
        .RESET_OUT (32'hA5),
        .RESET_DIR (32'h0F),
        .EDGE_TYPE (EDGE_RISE),
        .IRQ_MODE  (IRQ_EDGE)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .in_port  (in_port),
        .out_port (out_port),
        .out_en   (out_en),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        if (obs !== exp_v) begin
            failed++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic push_reg(input string tag, input logic [2:0] a, input logic [31:0] v);
        exp_t e;
        e.tag = tag; e.kind = K_REG; e.addr = a; e.val = v;
        sb.push_back(e);
    endtask

    task automatic push_sig(input string tag, input int kind, input logic [31:0] v);
        exp_t e;
        e.tag = tag; e.kind = kind; e.addr = 3'd0; e.val = v;
        sb.push_back(e);
    endtask

    // Called at a negedge; register reads step 1 ns each, well inside the half period.
    task automatic drain();
        exp_t e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = '0;
            case (e.kind)
                K_REG: begin
                    bus.address    = e.addr;
                    bus.chipselect = 1'b1;
                    bus.write_n    = 1'b1;
                    #1 obs = bus.readdata;
                end
                K_OUT: obs = {24'h0, out_port};
                K_DIR: obs = {24'h0, out_en};
                default: obs = {31'h0, irq};
            endcase
            chk(e.tag, obs, e.val);
        end
        bus.chipselect = 1'b0;
    endtask

    // Starts at a negedge, holds the strobe across one posedge, returns at the next negedge.
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n        = 1'b0;
        in_port        = '0;
        bus.address    = 3'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        cyc(2);
        reset_n = 1'b1;

        // Reset values
        push_sig("rst_out", K_OUT, 32'hA5);
        push_sig("rst_dir", K_DIR, 32'h0F);
        push_sig("rst_irq", K_IRQ, 32'h0);
        push_reg("rst_ecap", PIO_EDGECAP, 32'h0);
        push_reg("rst_mask", PIO_IRQMASK, 32'h0);
        push_reg("rst_dirrd", PIO_DIR, 32'h0F);
        drain();

        // Atomic set / clear
        wr(PIO_DATA, 32'h00);   push_sig("data_wr", K_OUT, 32'h00); drain();
        wr(PIO_OUTSET, 32'h81); push_sig("outset", K_OUT, 32'h81);  drain();
        wr(PIO_OUTCLR, 32'h01); push_sig("outclr", K_OUT, 32'h80);
        push_reg("outset_rd", PIO_OUTSET, 32'h0);
        push_reg("outclr_rd", PIO_OUTCLR, 32'h0);
        drain();

        // Mixed-direction DATA read; bits 0 and 2 rise as a side effect
        wr(PIO_DIR, 32'hF0);
        wr(PIO_DATA, 32'hA0);
        in_port = 8'h05;
        cyc(3);
        push_reg("mixed_rd", PIO_DATA, 32'hA5);
        push_reg("mixed_ecap", PIO_EDGECAP, 32'h05);
        push_sig("mixed_irq", K_IRQ, 32'h0);
        drain();
        wr(PIO_EDGECAP, 32'hFF);
        push_reg("w1c_all", PIO_EDGECAP, 32'h0);
        drain();
        in_port = 8'h00;
        cyc(3);
        push_reg("fall_ignored", PIO_EDGECAP, 32'h0);
        drain();

        // Edge-to-irq latency on bit 2
        wr(PIO_IRQMASK, 32'h04);
        in_port = 8'h04;
        cyc(2);
        push_reg("lat_k1_ecap", PIO_EDGECAP, 32'h0);
        push_reg("lat_k1_data", PIO_DATA, 32'hA4);
        drain();
        cyc(1);
        push_reg("lat_k2_ecap", PIO_EDGECAP, 32'h04);
        push_sig("lat_k2_irq", K_IRQ, 32'h0);
        drain();
        cyc(1);
        push_sig("lat_k3_irq", K_IRQ, 32'h1);
        drain();
        wr(PIO_EDGECAP, 32'h04);
        push_reg("clr_ecap", PIO_EDGECAP, 32'h0);
        push_sig("clr_irq_hold", K_IRQ, 32'h1);
        drain();
        cyc(1);
        push_sig("clr_irq_drop", K_IRQ, 32'h0);
        drain();

        // Capture and W1C hit bit 2 in the same cycle: capture wins
        in_port = 8'h00;
        cyc(4);
        push_reg("sim_pre", PIO_EDGECAP, 32'h0);
        drain();
        in_port = 8'h04;
        cyc(2);
        wr(PIO_EDGECAP, 32'h04);
        push_reg("sim_setwins", PIO_EDGECAP, 32'h04);
        drain();
        cyc(1);
        push_sig("sim_irq", K_IRQ, 32'h1);
        drain();

        // Upper writedata bits ignored, unmapped offsets inert
        wr(PIO_EDGECAP, 32'hFF);
        wr(PIO_IRQMASK, 32'hFFFF_FF00);
        wr(PIO_DATA, 32'h1234_5A66);
        wr(3'd6, 32'hFFFF_FFFF);
        wr(3'd7, 32'hFFFF_FFFF);
        push_reg("wide_mask", PIO_IRQMASK, 32'h0);
        push_sig("wide_out", K_OUT, 32'h66);
        push_reg("rd_off6", 3'd6, 32'h0);
        push_reg("rd_off7", 3'd7, 32'h0);
        push_reg("dir_keep", PIO_DIR, 32'hF0);
        push_sig("irq_idle", K_IRQ, 32'h0);
        drain();

        // Reset in the middle of activity, coincident with a DATA write
        wr(PIO_IRQMASK, 32'hFF);
        in_port = 8'h00;
        cyc(4);
        in_port = 8'hFF;
        cyc(4);
        push_reg("pre_ecap", PIO_EDGECAP, 32'hFF);
        push_sig("pre_irq", K_IRQ, 32'h1);
        drain();
        reset_n        = 1'b0;
        bus.address    = PIO_DATA;
        bus.writedata  = 32'h3C;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        reset_n        = 1'b1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        push_sig("mid_out", K_OUT, 32'hA5);
        push_sig("mid_dir", K_DIR, 32'h0F);
        push_sig("mid_irq", K_IRQ, 32'h0);
        push_reg("mid_ecap", PIO_EDGECAP, 32'h0);
        push_reg("mid_mask", PIO_IRQMASK, 32'h0);
        drain();
        cyc(1);
        push_sig("mid_irq_next", K_IRQ, 32'h0);
        drain();

        // Pin held high through reset gives one capture once synchronised
        cyc(2);
        push_reg("post_rst_ecap", PIO_EDGECAP, 32'hFF);
        push_reg("post_rst_data", PIO_DATA, 32'hF5);
        push_sig("post_rst_irq", K_IRQ, 32'h0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
